// File: rtl/frame_pkg.sv
// Shared sizes, frame-type codes, verdict codes, FSM encoding and CRC-32 helper
// for the frame validator.
package frame_pkg;

  localparam int unsigned DEF_DATA_SIZE     = 64;
  localparam int unsigned DEF_NONCE_SIZE    = 12;
  localparam int unsigned DEF_PREAMBLE_SIZE = 7;
  localparam int unsigned DEF_CRC_SIZE      = 4;

  localparam logic [7:0] TYPE_FIRST  = 8'h00;
  localparam logic [7:0] TYPE_LAST   = 8'h01;
  localparam logic [7:0] TYPE_NORMAL = 8'h02;
  localparam logic [7:0] TYPE_SINGLE = 8'h03;

  localparam logic [7:0] CODE_NONE  = 8'h00;
  localparam logic [7:0] CODE_OKAY  = 8'h05;
  localparam logic [7:0] CODE_ERROR = 8'h04;
  localparam logic [7:0] CODE_FATAL = 8'h08;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CRC_RUN = 3'd1,
    ST_CHECK   = 3'd2,
    ST_DELIVER = 3'd3,
    ST_CONFIRM = 3'd4
  } state_t;

  // One byte of reflected CRC-32 (LSB-first), no final XOR.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_engine.sv
// Byte-serial CRC-32 (IEEE, reflected). Only built when FRAME_CRC_CHECK_EN is
// defined; without it the validator carries no CRC logic at all.
`ifdef FRAME_CRC_CHECK_EN
module crc32_engine
  import frame_pkg::*;
(
  input  logic        clk,
  input  logic        init,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q;

  // Running remainder: preset on clear, folds in one byte per valid cycle.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      crc_q <= CRC32_INIT;
    end else if (clear) begin
      crc_q <= CRC32_INIT;
    end else if (byte_valid) begin
      crc_q <= crc32_byte(crc_q, byte_in);
    end
  end

  assign crc_out = crc_q ^ CRC32_XOROUT;

endmodule
`endif

// File: rtl/frame_validator.sv
// Frame validator: latches a received frame, optionally checks its CRC-32,
// checks type and sequence number, delivers the payload downstream and reports
// a one-cycle verdict. Optional CRC check enabled by macro FRAME_CRC_CHECK_EN.
module frame_validator
  import frame_pkg::*;
#(
  parameter  int unsigned DATA_SIZE     = DEF_DATA_SIZE,
  parameter  int unsigned NONCE_SIZE    = DEF_NONCE_SIZE,
  parameter  int unsigned PREAMBLE_SIZE = DEF_PREAMBLE_SIZE,
  parameter  int unsigned CRC_SIZE      = DEF_CRC_SIZE,
  localparam int unsigned FRAME_BYTES   = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE + NONCE_SIZE
) (
  input  logic                      clk,
  input  logic                      init,
  input  logic [FRAME_BYTES*8-1:0]  fin,
  input  logic                      fin_valid,
  output logic                      confirm,
  output logic [7:0]                conf_code,
  output logic [DATA_SIZE*8-1:0]    dout,
  output logic [NONCE_SIZE*8-1:0]   nonce_out,
  output logic                      first_out,
  output logic                      last_out,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      busy,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned FRAME_W   = FRAME_BYTES * 8;
  localparam int unsigned CRC_OFS   = PREAMBLE_SIZE + DATA_SIZE;
  localparam int unsigned NONCE_OFS = CRC_OFS + CRC_SIZE;

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  frame_q;
  logic                latch_c;
  logic [7:0]          ftype_c;
  logic [31:0]         fnum_c;
  logic                crc_done_c;
  logic                crc_ok_c;
  logic [7:0]          verdict_c;
  logic                pass_c;
  logic [31:0]         expected_q, exp_nxt_c;
  logic                in_seq_q, in_seq_nxt_c;

  assign latch_c = (state_q == ST_IDLE) && fin_valid;

  // Header fields: byte 0 type, bytes 3..6 big-endian frame number.
  assign ftype_c = frame_q[7:0];
  assign fnum_c  = {frame_q[3*8 +: 8], frame_q[4*8 +: 8], frame_q[5*8 +: 8], frame_q[6*8 +: 8]};

  // Frame holding register, captured only when a frame is accepted in IDLE.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      frame_q <= '0;
    end else if (latch_c) begin
      frame_q <= fin;
    end
  end

`ifdef FRAME_CRC_CHECK_EN
  localparam int unsigned IDX_W = $clog2(CRC_OFS + 1);

  logic [IDX_W-1:0] byte_idx_q;
  logic             crc_feed_c;
  logic [7:0]       crc_byte_c;
  logic [31:0]      crc_calc;
  logic [31:0]      crc_rx_c;

  assign crc_feed_c = (state_q == ST_CRC_RUN);
  assign crc_byte_c = frame_q[int'(byte_idx_q) * 8 +: 8];
  assign crc_done_c = (byte_idx_q == IDX_W'(CRC_OFS - 1));

  // Walks bytes 0..CRC_OFS-1 into the engine, one per CRC_RUN cycle.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      byte_idx_q <= '0;
    end else if (latch_c) begin
      byte_idx_q <= '0;
    end else if (crc_feed_c) begin
      byte_idx_q <= byte_idx_q + IDX_W'(1);
    end
  end

  // Received CRC field, big-endian.
  always_comb begin
    crc_rx_c = '0;
    for (int i = 0; i < int'(CRC_SIZE); i++) begin
      crc_rx_c = {crc_rx_c[23:0], frame_q[(CRC_OFS + i) * 8 +: 8]};
    end
  end

  crc32_engine u_crc (
    .clk        (clk),
    .init       (init),
    .clear      (latch_c),
    .byte_in    (crc_byte_c),
    .byte_valid (crc_feed_c),
    .crc_out    (crc_calc)
  );

  assign crc_ok_c = (crc_calc == crc_rx_c);
`else
  logic unused_frame_bits;

  assign crc_done_c        = 1'b1;
  assign crc_ok_c          = 1'b1;
  // Reserved and CRC bytes carry no meaning when the CRC is not checked.
  assign unused_frame_bits = ^{frame_q[8 +: 16], frame_q[CRC_OFS * 8 +: CRC_SIZE * 8]};
`endif

  // Verdict and next sequence-tracking values, consumed in CHECK.
  always_comb begin
    verdict_c    = CODE_OKAY;
    exp_nxt_c    = expected_q;
    in_seq_nxt_c = in_seq_q;
    if (ftype_c > TYPE_SINGLE) begin
      verdict_c    = CODE_FATAL;
      in_seq_nxt_c = 1'b0;
    end else if (!crc_ok_c) begin
      verdict_c = CODE_ERROR;
    end else begin
      case (ftype_c)
        TYPE_FIRST, TYPE_SINGLE: begin
          exp_nxt_c    = fnum_c + 32'd1;
          in_seq_nxt_c = (ftype_c == TYPE_FIRST);
        end
        default: begin
          if (!in_seq_q || (fnum_c != expected_q)) begin
            verdict_c = CODE_ERROR;
          end else begin
            exp_nxt_c    = expected_q + 32'd1;
            in_seq_nxt_c = (ftype_c == TYPE_NORMAL);
          end
        end
      endcase
    end
  end

  assign pass_c = (verdict_c == CODE_OKAY);

  // Sequence tracking is committed once per frame, in CHECK.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      expected_q <= '0;
      in_seq_q   <= 1'b0;
    end else if (state_q == ST_CHECK) begin
      expected_q <= exp_nxt_c;
      in_seq_q   <= in_seq_nxt_c;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fin_valid) begin
`ifdef FRAME_CRC_CHECK_EN
          state_d = ST_CRC_RUN;
`else
          state_d = ST_CHECK;
`endif
        end
      end
      ST_CRC_RUN: begin
        if (crc_done_c) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = pass_c ? ST_DELIVER : ST_CONFIRM;
      end
      ST_DELIVER: begin
        if (dout_ready) begin
          state_d = ST_CONFIRM;
        end
      end
      ST_CONFIRM: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      busy       <= 1'b0;
      confirm    <= 1'b0;
      dout_valid <= 1'b0;
      conf_code  <= CODE_NONE;
    end else begin
      busy       <= (state_d != ST_IDLE);
      confirm    <= (state_d == ST_CONFIRM);
      dout_valid <= (state_d == ST_DELIVER);
      if (state_d == ST_CONFIRM) begin
        conf_code <= (state_q == ST_CHECK) ? verdict_c : CODE_OKAY;
      end
    end
  end

  // Payload is loaded on a passing verdict and held until the next one.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      dout      <= '0;
      nonce_out <= '0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
    end else if ((state_q == ST_CHECK) && pass_c) begin
      dout      <= frame_q[PREAMBLE_SIZE * 8 +: DATA_SIZE * 8];
      nonce_out <= frame_q[NONCE_OFS * 8 +: NONCE_SIZE * 8];
      first_out <= (ftype_c == TYPE_FIRST) || (ftype_c == TYPE_SINGLE);
      last_out  <= (ftype_c == TYPE_LAST) || (ftype_c == TYPE_SINGLE);
    end
  end

  // Saturating count of frames offered while not IDLE.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      drop_cnt <= '0;
    end else if (fin_valid && (state_q != ST_IDLE) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_frame_validator.sv
// Scoreboard bench for frame_validator: stimulus pushes expected verdicts and
// payloads, a negedge monitor pops and compares them as the DUT presents them.
module tb_frame_validator;

  localparam int unsigned DATA_SIZE  = 64;
  localparam int unsigned NONCE_SIZE = 12;
  localparam int unsigned PRE        = 7;
  localparam int unsigned CRC_SIZE   = 4;
  localparam int unsigned FB         = PRE + DATA_SIZE + CRC_SIZE + NONCE_SIZE;
  localparam int unsigned FW         = FB * 8;
  localparam int unsigned DW         = DATA_SIZE * 8;
  localparam int unsigned NW         = NONCE_SIZE * 8;
  localparam int unsigned CRC_POS    = PRE + DATA_SIZE;
  localparam int unsigned NONCE_POS  = CRC_POS + CRC_SIZE;

`ifdef FRAME_CRC_CHECK_EN
  localparam int LAT_BAD = 73;
  localparam bit CRC_ON  = 1'b1;
`else
  localparam int LAT_BAD = 2;
  localparam bit CRC_ON  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          init;
  logic [FW-1:0] fin;
  logic          fin_valid;
  logic          confirm;
  logic [7:0]    conf_code;
  logic [DW-1:0] dout;
  logic [NW-1:0] nonce_out;
  logic          first_out;
  logic          last_out;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic [7:0]    drop_cnt;

  typedef struct {
    logic [7:0]    code;
    bit            pass;
    int            issue;
    logic [DW-1:0] data;
    logic [NW-1:0] nonce;
    bit            first;
    bit            last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_confirm = 0;

  frame_validator #(
    .DATA_SIZE     (DATA_SIZE),
    .NONCE_SIZE    (NONCE_SIZE),
    .PREAMBLE_SIZE (PRE),
    .CRC_SIZE      (CRC_SIZE)
  ) dut (
    .clk        (clk),
    .init       (init),
    .fin        (fin),
    .fin_valid  (fin_valid),
    .confirm    (confirm),
    .conf_code  (conf_code),
    .dout       (dout),
    .nonce_out  (nonce_out),
    .first_out  (first_out),
    .last_out   (last_out),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bit-serial reference CRC-32 over the preamble and data bytes.
  function automatic logic [31:0] ref_crc(input logic [FW-1:0] f);
    logic [31:0] r;
    logic [7:0]  b;
    r = 32'hFFFF_FFFF;
    for (int i = 0; i < int'(CRC_POS); i++) begin
      b = f[i*8 +: 8];
      for (int k = 0; k < 8; k++) begin
        if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB8_8320;
        else             r = r >> 1;
      end
    end
    return ~r;
  endfunction

  function automatic logic [FW-1:0] mk_frame(input logic [7:0] ty, input logic [31:0] num,
                                             input logic [7:0] seed);
    logic [FW-1:0] f;
    logic [31:0]   c;
    f = '0;
    f[7:0]    = ty;
    f[3*8 +: 8] = num[31:24];
    f[4*8 +: 8] = num[23:16];
    f[5*8 +: 8] = num[15:8];
    f[6*8 +: 8] = num[7:0];
    for (int i = 0; i < int'(DATA_SIZE); i++) f[(int'(PRE) + i)*8 +: 8] = seed + 8'(i * 3);
    c = ref_crc(f);
    f[(CRC_POS + 0)*8 +: 8] = c[31:24];
    f[(CRC_POS + 1)*8 +: 8] = c[23:16];
    f[(CRC_POS + 2)*8 +: 8] = c[15:8];
    f[(CRC_POS + 3)*8 +: 8] = c[7:0];
    for (int j = 0; j < int'(NONCE_SIZE); j++) f[(int'(NONCE_POS) + j)*8 +: 8] = seed ^ 8'(j * 17);
    return f;
  endfunction

  // Drive one frame strobe; optionally register its expected outcome.
  task automatic send(input logic [FW-1:0] f, input logic [7:0] code, input bit track);
    exp_t e;
    @(posedge clk);
    #1;
    fin       = f;
    fin_valid = 1'b1;
    e.code  = code;
    e.pass  = (code == 8'h05);
    e.issue = cyc;
    e.data  = f[PRE*8 +: DW];
    e.nonce = f[NONCE_POS*8 +: NW];
    e.first = (f[7:0] == 8'h00) || (f[7:0] == 8'h03);
    e.last  = (f[7:0] == 8'h01) || (f[7:0] == 8'h03);
    if (track) sb.push_back(e);
    @(posedge clk);
    #1;
    fin_valid = 1'b0;
  endtask

  task automatic wait_confirm();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = confirm;
    end
    chk("confirm_seen", DW'(seen), DW'(1));
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !busy;
    end
    chk("idle_reached", DW'(done), DW'(1));
  endtask

  // Monitor: payload checked every valid cycle, verdict popped on confirm.
  always @(negedge clk) begin
    if (!init) begin
      if (dout_valid) begin
        if (sb.size() == 0) begin
          chk("dout_valid_unexpected", DW'(dout_valid), DW'(0));
        end else begin
          chk("dout_valid", DW'(dout_valid), DW'(sb[0].pass));
          chk("dout", dout, sb[0].data);
          chk("nonce_out", DW'(nonce_out), DW'(sb[0].nonce));
          chk("first_out", DW'(first_out), DW'(sb[0].first));
          chk("last_out", DW'(last_out), DW'(sb[0].last));
          if (dout_ready) hs_cyc = cyc;
        end
      end
      if (confirm) begin
        n_confirm++;
        if (sb.size() == 0) begin
          chk("confirm_unexpected", DW'(confirm), DW'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("conf_code", DW'(conf_code), DW'(mon_e.code));
          if (mon_e.pass) chk("confirm_after_accept", DW'(cyc), DW'(hs_cyc + 1));
          else            chk("fail_latency", DW'(cyc - mon_e.issue), DW'(LAT_BAD));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] f;
    int            nc;
    init       = 1'b1;
    fin        = '0;
    fin_valid  = 1'b0;
    dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_confirm", DW'(confirm), DW'(0));
    chk("rst_conf_code", DW'(conf_code), DW'(0));
    chk("rst_dout_valid", DW'(dout_valid), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_drop_cnt", DW'(drop_cnt), DW'(0));
    chk("rst_dout", dout, DW'(0));
    chk("rst_first_out", DW'(first_out), DW'(0));
    init = 1'b0;
    repeat (2) @(negedge clk);

    // FIRST 5 then NORMAL 6 issued in the cycle after confirm.
    send(mk_frame(8'h00, 32'h0000_0005, 8'h11), 8'h05, 1'b1);
    wait_confirm();
    send(mk_frame(8'h02, 32'h0000_0006, 8'h22), 8'h05, 1'b1);
    wait_idle();

    // Out-of-order number rejected, then the expected one accepted.
    send(mk_frame(8'h02, 32'h0000_0009, 8'h23), 8'h04, 1'b1);
    wait_idle();
    send(mk_frame(8'h02, 32'h0000_0007, 8'h24), 8'h05, 1'b1);
    wait_idle();

    // Corrupted data byte: caught only when the CRC is checked.
    f = mk_frame(8'h02, 32'h0000_0008, 8'h44);
    f[(PRE + 20)*8 +: 8] = f[(PRE + 20)*8 +: 8] ^ 8'hFF;
    send(f, CRC_ON ? 8'h04 : 8'h05, 1'b1);
    wait_idle();

    // Bad type is fatal and breaks the sequence.
    send(mk_frame(8'h09, 32'h0000_0009, 8'h55), 8'h08, 1'b1);
    wait_idle();
    send(mk_frame(8'h02, 32'h0000_0009, 8'h56), 8'h04, 1'b1);
    wait_idle();

    // Stalled delivery with a second frame offered 10 cycles in.
    dout_ready = 1'b0;
    send(mk_frame(8'h03, 32'h0000_0064, 8'h5A), 8'h05, 1'b1);
    repeat (8) @(posedge clk);
    send(mk_frame(8'h02, 32'h0000_0001, 8'h77), 8'h05, 1'b0);
    begin
      bit seen_dv;
      seen_dv = 1'b0;
      for (int i = 0; i < 200 && !seen_dv; i++) begin
        @(negedge clk);
        seen_dv = dout_valid;
      end
      chk("stall_dout_valid_seen", DW'(seen_dv), DW'(1));
    end
    repeat (20) @(posedge clk);
    #1;
    dout_ready = 1'b1;
    wait_idle();
    chk("drop_cnt_one", DW'(drop_cnt), DW'(1));

    // Reset in the middle of a frame: everything cleared, no confirm.
    dout_ready = 1'b0;
    send(mk_frame(8'h00, 32'h0000_00C8, 8'h33), 8'h05, 1'b1);
    repeat (29) @(posedge clk);
    #2;
    init = 1'b1;
    #1;
    chk("init_confirm", DW'(confirm), DW'(0));
    chk("init_conf_code", DW'(conf_code), DW'(0));
    chk("init_dout_valid", DW'(dout_valid), DW'(0));
    chk("init_dout", dout, DW'(0));
    chk("init_nonce_out", DW'(nonce_out), DW'(0));
    chk("init_first_out", DW'(first_out), DW'(0));
    chk("init_last_out", DW'(last_out), DW'(0));
    chk("init_busy", DW'(busy), DW'(0));
    chk("init_drop_cnt", DW'(drop_cnt), DW'(0));
    sb.delete();
    @(negedge clk);
    init       = 1'b0;
    dout_ready = 1'b1;
    nc = n_confirm;
    repeat (100) @(posedge clk);
    #1;
    chk("no_confirm_after_init", DW'(n_confirm), DW'(nc));
    chk("idle_after_init", DW'(busy), DW'(0));

    // Sequence cleared by reset; then 32-bit wrap and LAST closing a sequence.
    send(mk_frame(8'h02, 32'h0000_00C9, 8'h61), 8'h04, 1'b1);
    wait_idle();
    send(mk_frame(8'h00, 32'hFFFF_FFFF, 8'h62), 8'h05, 1'b1);
    wait_idle();
    send(mk_frame(8'h02, 32'h0000_0000, 8'h63), 8'h05, 1'b1);
    wait_idle();
    send(mk_frame(8'h01, 32'h0000_0001, 8'h64), 8'h05, 1'b1);
    wait_idle();
    send(mk_frame(8'h02, 32'h0000_0002, 8'h65), 8'h04, 1'b1);
    wait_idle();

    chk("scoreboard_empty", DW'(sb.size()), DW'(0));
    chk("final_drop_cnt", DW'(drop_cnt), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
